// File: rtl/cnt_rr_scheduler.sv
// cnt_rr_scheduler: round-robin arbiter that time-shares one load/enable/done counter among NREQ requesters.
// Optional RUN-phase timeout abort is compiled in when CNT_RR_SCHEDULER_TIMEOUT_EN is defined.
module cnt_rr_scheduler #(
  parameter int NREQ        = 4,
  parameter int BITS        = 16,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] req_value,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [BITS-1:0]      result,
  output logic                 err,
  output logic                 busy,
  output logic                 ctr_load,
  output logic                 ctr_enable,
  output logic [BITS-1:0]      ctr_value,
  input  logic                 ctr_done,
  input  logic [BITS-1:0]      ctr_count,
  output logic [2:0]           dbg_state
);

  localparam int PW  = $clog2(NREQ);
  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam bit CFG_OK = (NREQ >= 2) && (NREQ <= 8) && (LOAD_CYCLES >= 1) && (TIMEOUT >= 2);

  // Elaboration guard: an unsupported parameter set leaves this named block in the hierarchy.
  if (!CFG_OK) begin : g_cfg_unsupported
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            r_state, w_state_n;
  logic [PW-1:0]     r_win, w_win_n;
  logic [PW-1:0]     r_ptr, w_ptr_n;
  logic [PW-1:0]     w_pick;
  logic [LCW-1:0]    r_lcnt, w_lcnt_n;
  logic [NREQ-1:0]   r_gnt, w_gnt_n;
  logic [NREQ-1:0]   r_done, w_done_n;
  logic [BITS-1:0]   r_result, w_result_n;
  logic [BITS-1:0]   r_value, w_value_n;
  logic              r_load, w_load_n;
  logic              r_enable, w_enable_n;
  logic              r_busy, w_busy_n;

`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]     r_tcnt, w_tcnt_n;
  logic              r_err, w_err_n;
`endif

  // First set request bit found scanning p, p+1, ... (mod NREQ).
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    int            idx;
    w = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % NREQ;
      if (r[idx]) w = PW'(idx);
    end
    return w;
  endfunction

  assign w_pick = rr_pick(req, r_ptr);

  // Counter handshake: ctr_load and ctr_enable are levels owned by this block; ctr_done is a
  // one-cycle pulse that qualifies ctr_count and is accepted only while in RUN (ignored elsewhere).
  always_comb begin
    w_state_n  = r_state;
    w_win_n    = r_win;
    w_ptr_n    = r_ptr;
    w_lcnt_n   = r_lcnt;
    w_gnt_n    = r_gnt;
    w_done_n   = '0;
    w_result_n = r_result;
    w_value_n  = r_value;
    w_load_n   = r_load;
    w_enable_n = r_enable;
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
    w_tcnt_n   = r_tcnt;
    w_err_n    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_win_n   = w_pick;
          w_gnt_n   = NREQ'(1) << w_pick;
          w_value_n = req_value[int'(w_pick)*BITS +: BITS];
          w_state_n = S_GRANT;
        end
      end
      S_GRANT: begin
        w_load_n  = 1'b1;
        w_lcnt_n  = '0;
        w_state_n = S_LOAD;
      end
      S_LOAD: begin
        if (r_lcnt == LCW'(LOAD_CYCLES - 1)) begin
          w_load_n   = 1'b0;
          w_enable_n = 1'b1;
          w_state_n  = S_RUN;
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
          w_tcnt_n   = '0;
`endif
        end else begin
          w_lcnt_n = r_lcnt + 1'b1;
        end
      end
      S_RUN: begin
        // A completion on the expiry edge takes priority over the abort.
        if (ctr_done) begin
          w_result_n = ctr_count;
          w_enable_n = 1'b0;
          w_done_n   = NREQ'(1) << r_win;
          w_state_n  = S_RESP;
        end
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
        else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_result_n = '0;
          w_enable_n = 1'b0;
          w_done_n   = NREQ'(1) << r_win;
          w_err_n    = 1'b1;
          w_state_n  = S_RESP;
        end else begin
          w_tcnt_n = r_tcnt + 1'b1;
        end
`endif
      end
      S_RESP: begin
        w_gnt_n   = '0;
        w_ptr_n   = PW'((int'(r_win) + 1) % NREQ);
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_win    <= '0;
      r_ptr    <= '0;
      r_lcnt   <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_value  <= '0;
      r_load   <= 1'b0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
      r_tcnt   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_n;
      r_win    <= w_win_n;
      r_ptr    <= w_ptr_n;
      r_lcnt   <= w_lcnt_n;
      r_gnt    <= w_gnt_n;
      r_done   <= w_done_n;
      r_result <= w_result_n;
      r_value  <= w_value_n;
      r_load   <= w_load_n;
      r_enable <= w_enable_n;
      r_busy   <= w_busy_n;
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
      r_tcnt   <= w_tcnt_n;
      r_err    <= w_err_n;
`endif
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign result     = r_result;
  assign busy       = r_busy;
  assign ctr_load   = r_load;
  assign ctr_enable = r_enable;
  assign ctr_value  = r_value;
  assign dbg_state  = r_state;

`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_rr_scheduler.sv
// Bench for cnt_rr_scheduler: directed jobs plus randomized jobs, scoreboarded against a round-robin model.
// Build with or without CNT_RR_SCHEDULER_TIMEOUT_EN; the timeout section adapts its expectations.
module tb_cnt_rr_scheduler;

  localparam int NREQ = 4;
  localparam int BITS = 16;
  localparam int LC   = 2;
  localparam int TO   = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*BITS-1:0] req_value = '0;
  logic [NREQ-1:0]      gnt, done;
  logic [BITS-1:0]      result, ctr_value;
  logic                 err, busy, ctr_load, ctr_enable;
  logic                 ctr_done = 1'b0;
  logic [BITS-1:0]      ctr_count = '0;
  logic [2:0]           dbg_state;

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;

  logic [31:0] exp_gnt_q[$];
  logic [31:0] exp_done_q[$];

  // clock / reset
  always #5 clk = ~clk;

  cnt_rr_scheduler #(
    .NREQ(NREQ), .BITS(BITS), .LOAD_CYCLES(LC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_value(req_value),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .ctr_load(ctr_load), .ctr_enable(ctr_enable), .ctr_value(ctr_value),
    .ctr_done(ctr_done), .ctr_count(ctr_count), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: winner is the first requester at or after the pointer, wrapping around.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic check_all_zero(input string name);
    check(name, {gnt, done, result, err, busy, ctr_load, ctr_enable, ctr_value}, 64'd0);
  endtask

  // mode 0: normal completion, 1: reset pulse during RUN, 2: return once RUN is reached (no ctr_done)
  task automatic run_job(input logic [NREQ-1:0] r, input logic [NREQ*BITS-1:0] vals,
                         input int exp_win, input int exp_lat, input logic [NREQ-1:0] post_req,
                         input int delay, input bit stray, input int mode,
                         input logic [BITS-1:0] cnt);
    logic [NREQ-1:0] oh;
    int n, nl;
    oh = NREQ'(1) << exp_win;
    req = r;
    req_value = vals;
    exp_gnt_q.push_back(32'({oh, vals[exp_win*BITS +: BITS]}));
    if (mode == 0) exp_done_q.push_back(32'({oh, cnt, 1'b0}));
    if (mode == 2) begin
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
      exp_done_q.push_back(32'({oh, {BITS{1'b0}}, 1'b1}));
`else
      exp_done_q.push_back(32'({oh, cnt, 1'b0}));
`endif
    end
    if (mode != 1) model_ptr = (exp_win + 1) % NREQ;

    @(negedge clk);
    n = 1;
    while (gnt == '0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("gnt_latency", n, exp_lat);
    req = post_req;
    req_value = {$urandom(), $urandom()};

    nl = 0;
    n = 0;
    @(negedge clk);
    while (!ctr_enable && n < 16) begin
      if (ctr_load) nl++;
      ctr_done  = stray && (nl == 1) && ctr_load;
      ctr_count = BITS'($urandom());
      @(negedge clk);
      n++;
    end
    ctr_done = 1'b0;
    check("load_cycles", nl, LC);
    check("enable_seen", ctr_enable, 1);
    check("load_off_in_run", ctr_load, 0);
    if (mode == 2) return;

    repeat (delay) @(negedge clk);
    if (mode == 1) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset_mid_run_outputs");
      check("reset_mid_run_enable", ctr_enable, 0);
      check("reset_mid_run_gnt", gnt, 0);
      model_ptr = 0;
      return;
    end
    ctr_done  = 1'b1;
    ctr_count = cnt;
    @(negedge clk);
    ctr_done  = 1'b0;
    ctr_count = BITS'($urandom());
    n = 0;
    while (done == '0 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("done_latency", n, 0);
  endtask

  // scoreboard monitor
  logic [NREQ-1:0] prev_gnt = '0;
  logic [BITS-1:0] cur_val  = '0;
  logic [31:0]     e;
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
    end else begin
      if (gnt != '0 && prev_gnt == '0) begin
        if (exp_gnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gnt: got %b expected no grant", gnt);
        end else begin
          e = exp_gnt_q.pop_front();
          cur_val = e[BITS-1:0];
          check("gnt_onehot", gnt, e[BITS +: NREQ]);
        end
      end
      if (gnt != '0) check("ctr_value_stable", ctr_value, cur_val);
      if (done != '0) begin
        check("done_with_gnt", done & ~gnt, 0);
        if (exp_done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got %b expected no done", done);
        end else begin
          e = exp_done_q.pop_front();
          check("done_onehot", done, e[BITS+1 +: NREQ]);
          check("result", result, e[1 +: BITS]);
          check("err", err, e[0]);
        end
      end else if (err) begin
        checks++;
        failures++;
        $display("FAIL err_without_done: got err=1 expected 0");
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  int fair_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [NREQ*BITS-1:0] vals;
    logic [NREQ-1:0]      r;
    logic [BITS-1:0]      cnt;
    int w, lat, gap, ne;
    bit ok;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    check("reset_dbg_state", dbg_state, 0);
    rst = 1'b0;

    // single job on requester 2
    vals = '0;
    vals[2*BITS +: BITS] = 16'h0010;
    run_job(4'b0100, vals, 2, 1, 4'b0000, 20, 1'b0, 0, 16'h03E8);
    req = '0;
    @(negedge clk);
    check("busy_after_job", busy, 0);
    check("gnt_after_job", gnt, 0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;

    // fairness with all requests held
    lat = 1;
    foreach (fair_order[k]) begin
      run_job(4'b1111, {$urandom(), $urandom()}, fair_order[k], lat, 4'b1111,
              $urandom_range(0, 5), 1'b0, 0, BITS'($urandom()));
      lat = 2;
    end

    // pointer skip: after requester 1, 0011 goes to requester 0
    run_job(4'b0010, {$urandom(), $urandom()}, 1, 2, 4'b0000, 3, 1'b0, 0, BITS'($urandom()));
    run_job(4'b0011, {$urandom(), $urandom()}, 0, 2, 4'b0000, 2, 1'b0, 0, BITS'($urandom()));
    req = '0;
    @(negedge clk);

    // stray ctr_done during LOAD
    run_job(4'b0001, {$urandom(), $urandom()}, 0, 1, 4'b0000, 5, 1'b1, 0, 16'hBEEF);

    // reset during RUN, then the pointer restarts at requester 0
    run_job(4'b0100, {$urandom(), $urandom()}, 2, 2, 4'b0000, 3, 1'b0, 1, 16'h0000);
    run_job(4'b0011, {$urandom(), $urandom()}, 0, 1, 4'b0000, 2, 1'b0, 0, 16'h5A5A);

    // randomized jobs
    lat = 2;
    for (int j = 0; j < 40; j++) begin
      r = NREQ'($urandom_range(1, 15));
      vals = {$urandom(), $urandom()};
      w = model_pick(r, model_ptr);
      if ($urandom_range(0, 3) == 0) vals[w*BITS +: BITS] = '0;
      cnt = ($urandom_range(0, 3) == 0) ? '0 : BITS'($urandom());
      run_job(r, vals, w, lat, NREQ'($urandom_range(0, 15)), $urandom_range(0, 12),
              $urandom_range(0, 3) == 0, 0, cnt);
      gap = $urandom_range(0, 2);
      req = '0;
      repeat (gap) @(negedge clk);
      lat = (gap > 0) ? 1 : 2;
    end

    // counter that never completes
    cnt = 16'h1234;
    w = model_pick(4'b1000, model_ptr);
    run_job(4'b1000, {$urandom(), $urandom()}, w, lat, 4'b0000, 0, 1'b0, 2, cnt);
`ifdef CNT_RR_SCHEDULER_TIMEOUT_EN
    ne = 0;
    while (ctr_enable && ne < 3000) begin
      ne++;
      @(negedge clk);
    end
    check("timeout_enable_cycles", ne, TO);
    check("timeout_done", done, 4'b1000);
    check("timeout_err", err, 1);
`else
    ok = 1'b1;
    ne = 0;
    repeat (1100) begin
      if (!ctr_enable || err || done != '0) ok = 1'b0;
      ne++;
      @(negedge clk);
    end
    check("no_timeout_hold", ok, 1);
    ctr_done  = 1'b1;
    ctr_count = cnt;
    @(negedge clk);
    ctr_done = 1'b0;
    check("late_done", done, 4'b1000);
`endif

    req = '0;
    repeat (3) @(negedge clk);
    check("exp_gnt_q_empty", exp_gnt_q.size(), 0);
    check("exp_done_q_empty", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_rr_scheduler.md
Name: cnt_rr_scheduler

Overview:
- Round-robin scheduler that shares one LA-driven load/enable/done counter among NREQ requesters.
- Arbitrates pending requests and latches the winner's preload value.
- Sequences the counter through load, run and done, then returns the captured count to the winner with a one-cycle done pulse.
- Sits between requester logic (LA-decoded commands or other user blocks) and the shared counter instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BITS, 16, counter/value width.
- LOAD_CYCLES, 2, cycles ctr_load is held before ctr_enable rises (>=1).
- TIMEOUT, 2048, max RUN cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester level request.
- req_value  in  NREQ*BITS  preload values, slice i = [i*BITS +: BITS].
- gnt  out  NREQ  one-hot grant, high from GRANT through RESP.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- result  out  BITS  count returned to the winner; held until next RESP.
- err  out  1  one-cycle pulse with done on timeout abort; tied 0 without the optional feature.
- busy  out  1  high in every state except IDLE.
- ctr_load  out  1  load request to the counter.
- ctr_enable  out  1  run request to the counter.
- ctr_value  out  BITS  latched preload value for the counter.
- ctr_done  in  1  one-cycle done pulse from the counter.
- ctr_count  in  BITS  counter result, valid while ctr_done=1.

Behaviour:
- All outputs registered.
- Reset values: every output 0. Internally, state=IDLE, rr_ptr=0, load/timeout counters 0.
- rst asserted mid-operation: next edge forces the reset values, including ctr_load/ctr_enable=0. No done pulse is issued for the aborted job.
- States: IDLE -> GRANT -> LOAD -> RUN -> RESP -> IDLE.
- IDLE:
  - If any req bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - Next edge: gnt[win]=1, ctr_value<=req_value[win], go to GRANT.
  - Nothing is granted in the same cycle a request first appears.
- GRANT: one cycle. ctr_load<=1, go to LOAD.
- LOAD:
  - ctr_load held for LOAD_CYCLES cycles, ctr_enable=0.
  - On the final LOAD cycle: ctr_load<=0, ctr_enable<=1, go to RUN.
  - ctr_done in GRANT or LOAD is ignored.
- RUN:
  - ctr_enable held high.
  - On ctr_done=1: result<=ctr_count, ctr_enable<=0, go to RESP.
  - ctr_value is stable through GRANT, LOAD and RUN.
- RESP:
  - One cycle. done[win]=1. gnt cleared on exit.
  - rr_ptr<=(win+1) mod NREQ. Return to IDLE.
- Latency: req high at edge k (scheduler idle) gives gnt at k+1, ctr_load k+2..k+1+LOAD_CYCLES, ctr_enable from k+2+LOAD_CYCLES.
  - ctr_done at edge m gives done pulse at m+1.
  - Minimum gap between successive grants: one IDLE cycle.
- Requests:
  - req is level-sensitive and sampled only in IDLE. Changes during a job have no effect on it.
  - A requester still asserting req after its done pulse is re-eligible, ordered after all others by rr_ptr.
  - req_value may change after gnt without effect.
- Simultaneous requests: strict round-robin from rr_ptr. No requester waits more than NREQ-1 jobs.
- Value 0 is loaded and run like any other value.
- done and err never assert without a matching gnt bit.

Optional Feature:
- Macro: CNT_RR_SCHEDULER_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter starts at 0 on entry to RUN.
  - If it reaches TIMEOUT-1 without ctr_done: ctr_enable<=0, result<=0, go to RESP, err=1 alongside done[win].
  - rr_ptr advances as normal.
  - ctr_done on the same edge as expiry wins: normal completion, err=0.
- Undefined: no timer logic, err tied 0, RUN waits for ctr_done indefinitely.

Test Plan:
- Single job: after reset, req[2]=1, req_value slice 2=16'h0010; counter model pulses ctr_done 20 cycles after enable with ctr_count=16'h03E8 -> gnt=4'b0100 one cycle after req; ctr_load high exactly 2 cycles; ctr_value=16'h0010; done=4'b0100 for one cycle; result=16'h03E8; busy back to 0.
- Fairness: req=4'b1111 held continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each done pulses exactly once per job.
- Pointer skip: after a job for requester 1, req=4'b0011 -> next grant goes to requester 0, not 1.
- Reset mid-RUN: rst high for 1 cycle during RUN -> next edge all outputs 0, including ctr_enable and gnt; no done pulse; the next job is granted starting from requester 0.
- Stray done: ctr_done pulsed during LOAD -> ignored; scheduler still enters RUN and completes on the later ctr_done.
- With CNT_RR_SCHEDULER_TIMEOUT_EN, TIMEOUT=64, ctr_done never pulsed -> ctr_enable drops after 64 RUN cycles; done[win] and err pulse together; result=0. Without the macro, the same stimulus keeps ctr_enable high 1000+ cycles and err stays 0.
